// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, output-port indices and the XY route helper.
package noc_pkg;

   localparam int unsigned FLIT_W       = 20;
   localparam int unsigned COORD_W      = 2;
   localparam int unsigned CREDIT_DEPTH = 4;

   localparam int unsigned DST_X_MSB = 19;
   localparam int unsigned DST_X_LSB = 18;
   localparam int unsigned DST_Y_MSB = 17;
   localparam int unsigned DST_Y_LSB = 16;

   localparam int unsigned NUM_PORTS  = 5;
   localparam int unsigned PORT_LOCAL = 0;
   localparam int unsigned PORT_EAST  = 1;
   localparam int unsigned PORT_WEST  = 2;
   localparam int unsigned PORT_NORTH = 3;
   localparam int unsigned PORT_SOUTH = 4;

   typedef logic [NUM_PORTS-1:0] port_vec_t;

   // Dimension-ordered routing: resolve X first, then Y, else eject locally.
   function automatic port_vec_t route_xy(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy,
                                          input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
      port_vec_t r;
      r = '0;
      if (dx > x)      r[PORT_EAST]  = 1'b1;
      else if (dx < x) r[PORT_WEST]  = 1'b1;
      else if (dy > y) r[PORT_NORTH] = 1'b1;
      else if (dy < y) r[PORT_SOUTH] = 1'b1;
      else             r[PORT_LOCAL] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO; full/empty derive from the count, pushes into a full FIFO
// with no concurrent pop are dropped and reported.
module flit_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned FLIT_W = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [FLIT_W-1:0]        wr_data,
   input  logic                     pop,
   output logic [FLIT_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     popped,
   output logic                     dropped
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [FLIT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dropped = push & ~do_push;
   assign popped  = do_pop;
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
         else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/router_local_inport.sv
// Router local input port: buffers PE flits, returns credits on dequeue and
// presents the XY route request of the head flit to the switch allocator.
module router_local_inport #(
   parameter int unsigned DEPTH   = noc_pkg::CREDIT_DEPTH,
   parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
   parameter int unsigned COORD_W = noc_pkg::COORD_W,
   parameter int unsigned X_COORD = 0,
   parameter int unsigned Y_COORD = 0
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic [FLIT_W-1:0]       flit_in,
   input  logic                    flit_in_valid,
   output logic                    credit_out,
   output logic [4:0]              req,
   output logic [FLIT_W-1:0]       flit_out,
   input  logic                    grant,
   output logic [$clog2(DEPTH):0]  occupancy,
   output logic                    overflow_err
);

   import noc_pkg::*;

   localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORD);
   localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORD);

   logic      full, empty, popped, dropped;
   logic      credit_q, overflow_q;
   port_vec_t route;

   flit_fifo #(
      .DEPTH  (DEPTH),
      .FLIT_W (FLIT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (RST),
      .push    (flit_in_valid),
      .wr_data (flit_in),
      .pop     (grant),
      .rd_data (flit_out),
      .full    (full),
      .empty   (empty),
      .count   (occupancy),
      .popped  (popped),
      .dropped (dropped)
   );

   always_comb begin
      route = route_xy(flit_out[DST_X_MSB:DST_X_LSB], flit_out[DST_Y_MSB:DST_Y_LSB],
                       MY_X, MY_Y);
   end

   assign req = route & {5{~empty}};

   always_ff @(posedge clk) begin
      if (!RST) begin
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         credit_q <= popped;
         if (dropped) overflow_q <= 1'b1;
      end
   end

   assign credit_out   = credit_q;
   assign overflow_err = overflow_q;

   logic unused_full;
   assign unused_full = full;

endmodule

// File: tb/tb_router_local_inport.sv
// Randomized and directed bench for router_local_inport against a queue-based model.
module tb_router_local_inport;

   localparam int X = 1;
   localparam int Y = 1;

   logic        clk = 1'b0;
   logic        RST;
   logic [19:0] flit_in;
   logic        flit_in_valid;
   logic        credit_out;
   logic [4:0]  req;
   logic [19:0] flit_out;
   logic        grant;
   logic [2:0]  occupancy;
   logic        overflow_err;

   router_local_inport #(
      .DEPTH   (4),
      .FLIT_W  (20),
      .COORD_W (2),
      .X_COORD (X),
      .Y_COORD (Y)
   ) dut (
      .clk           (clk),
      .RST           (RST),
      .flit_in       (flit_in),
      .flit_in_valid (flit_in_valid),
      .credit_out    (credit_out),
      .req           (req),
      .flit_out      (flit_out),
      .grant         (grant),
      .occupancy     (occupancy),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [19:0] mq[$];
   logic        exp_credit = 1'b0;
   logic        exp_ovf    = 1'b0;
   int          credits;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] model_req();
      int dx, dy;
      if (mq.size() == 0) return 5'b0;
      dx = int'(mq[0][19:18]);
      dy = int'(mq[0][17:16]);
      if (dx > X) return 5'b00010;
      if (dx < X) return 5'b00100;
      if (dy > Y) return 5'b01000;
      if (dy < Y) return 5'b10000;
      return 5'b00001;
   endfunction

   // Apply one cycle of inputs, compare mid-cycle, then advance the model at the edge.
   task automatic step(input logic v, input logic [19:0] f, input logic g, input logic r);
      int sz;
      flit_in_valid = v;
      flit_in       = f;
      grant         = g;
      RST           = r;
      @(negedge clk);
      check_eq("occupancy", 32'(occupancy), 32'(mq.size()));
      check_eq("credit", 32'(credit_out), 32'(exp_credit));
      check_eq("overflow", 32'(overflow_err), 32'(exp_ovf));
      check_eq("req", 32'(req), 32'(model_req()));
      if (mq.size() > 0) check_eq("flit_out", 32'(flit_out), 32'(mq[0]));
      @(posedge clk);
      if (!r) begin
         mq.delete();
         exp_credit = 1'b0;
         exp_ovf    = 1'b0;
      end else begin
         sz = mq.size();
         exp_credit = g && (sz > 0);
         if (exp_credit) void'(mq.pop_front());
         if (v) begin
            if (sz < 4 || exp_credit) mq.push_back(f);
            else exp_ovf = 1'b1;
         end
      end
      #1;
   endtask

   logic [19:0] route_flits [4];
   logic [4:0]  route_reqs  [4];

   initial begin
      route_flits[0] = 20'hC0000; route_reqs[0] = 5'b00010;
      route_flits[1] = 20'h0AAAA; route_reqs[1] = 5'b00100;
      route_flits[2] = 20'h50000; route_reqs[2] = 5'b00001;
      route_flits[3] = 20'h60000; route_reqs[3] = 5'b01000;

      RST = 1'b0; flit_in_valid = 1'b1; flit_in = 20'h12345; grant = 1'b0;
      @(posedge clk); #1;

      // Reset held with valid asserted
      for (int i = 0; i < 3; i++) step(1'b1, 20'h12345, 1'b0, 1'b0);
      check_eq("rst_occ", 32'(occupancy), 32'd0);
      check_eq("rst_req", 32'(req), 32'd0);

      // Routing
      for (int i = 0; i < 4; i++) begin
         step(1'b1, route_flits[i], 1'b0, 1'b1);
         check_eq("route_req", 32'(req), 32'(route_reqs[i]));
         step(1'b0, 20'h0, 1'b1, 1'b1);
      end
      step(1'b0, 20'h0, 1'b0, 1'b1);

      // Single flit grant/credit
      step(1'b1, 20'h51234, 1'b0, 1'b1);
      check_eq("gc_flit", 32'(flit_out), 32'h51234);
      check_eq("gc_credit_before", 32'(credit_out), 32'd0);
      step(1'b0, 20'h0, 1'b1, 1'b1);
      check_eq("gc_credit", 32'(credit_out), 32'd1);
      check_eq("gc_occ", 32'(occupancy), 32'd0);
      step(1'b0, 20'h0, 1'b0, 1'b1);
      check_eq("gc_credit_after", 32'(credit_out), 32'd0);

      // Fill, overflow, drain
      for (int i = 0; i < 4; i++) step(1'b1, 20'($urandom), 1'b0, 1'b1);
      check_eq("fill_occ", 32'(occupancy), 32'd4);
      step(1'b1, 20'hFFFFF, 1'b0, 1'b1);
      check_eq("fill_ovf", 32'(overflow_err), 32'd1);
      credits = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 20'h0, 1'b1, 1'b1);
         credits += int'(credit_out);
      end
      check_eq("drain_credits", 32'(credits), 32'd4);
      check_eq("drain_ovf_sticky", 32'(overflow_err), 32'd1);
      step(1'b0, 20'h0, 1'b0, 1'b0);

      // Full with simultaneous push and pop across pointer wrap
      for (int i = 0; i < 4; i++) step(1'b1, 20'($urandom), 1'b0, 1'b1);
      credits = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 20'($urandom), 1'b1, 1'b1);
         credits += int'(credit_out);
         check_eq("pp_occ", 32'(occupancy), 32'd4);
      end
      check_eq("pp_credits", 32'(credits), 32'd6);
      check_eq("pp_ovf", 32'(overflow_err), 32'd0);
      for (int i = 0; i < 5; i++) step(1'b0, 20'h0, 1'b1, 1'b1);

      // Empty grant and mid-run reset
      step(1'b0, 20'h0, 1'b1, 1'b1);
      check_eq("empty_grant_credit", 32'(credit_out), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 20'($urandom), 1'b0, 1'b1);
      step(1'b0, 20'h0, 1'b1, 1'b0);
      check_eq("mid_rst_occ", 32'(occupancy), 32'd0);
      check_eq("mid_rst_credit", 32'(credit_out), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) < 6, 20'($urandom), $urandom_range(0, 9) < 5,
              $urandom_range(0, 63) != 0);
      end
      step(1'b0, 20'h0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
